// File: rtl/move_scheduler.sv
// move_scheduler: queues destination addresses, starts one mover transfer each, reports completion
module move_scheduler #(
    parameter int unsigned BYTE_COUNT     = 1048576,
    parameter int unsigned BURST_SIZE     = 4096,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr_in_tdata,
    input  logic        addr_in_tvalid,
    output logic        addr_in_tready,
    output logic        mover_start,
    output logic [63:0] mover_dest_address,
    input  logic        dst_bvalid,
    input  logic [1:0]  dst_bresp,
    output logic [63:0] done_tdata,
    output logic [2:0]  done_tuser,
    output logic        done_tvalid,
    input  logic        done_tready,
    output logic        busy,
    output logic [31:0] moves_completed,
    output logic [15:0] error_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] BURSTS = 32'(BYTE_COUNT / BURST_SIZE);
    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, START, WAIT_B, REPORT} state_t;
    state_t state, state_d;
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_d;
    logic [31:0] bcount, timer;
    logic [1:0] worst;
    logic timeout, push, store, drop, pop, stray, done_hs, bad_done;
    logic [1:0] err_inc;
    logic [16:0] err_sum;
    assign push = addr_in_tvalid && addr_in_tready;
    assign store = push && addr_in_tdata != 64'd0;
    assign drop = push && addr_in_tdata == 64'd0;
    assign stray = dst_bvalid && state != WAIT_B;
    assign done_hs = state == REPORT && done_tready;
    assign bad_done = done_hs && (timeout || worst != 2'd0);
    assign err_inc = 2'(drop) + 2'(stray) + 2'(bad_done);
    assign err_sum = {1'b0, error_count} + 17'(err_inc);
    assign count_d = count + (AW+1)'(store) - (AW+1)'(pop);
    assign mover_start = state == START;
    assign done_tvalid = state == REPORT;
    assign done_tdata = state == REPORT ? mover_dest_address : 64'd0;
    assign done_tuser = state == REPORT ? {timeout, worst} : 3'd0;
    assign busy = state != IDLE || count != '0;
    always_comb begin
        state_d = state;
        pop = 1'b0;
        unique case (state)
            IDLE: begin
                pop = count != '0;
                state_d = pop ? START : IDLE;
            end
            START: state_d = WAIT_B;
            WAIT_B: state_d = (dst_bvalid ? bcount + 32'd1 == BURSTS : timer + 32'd1 == TMO) ? REPORT : WAIT_B;
            REPORT: state_d = done_tready ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (store) mem[wr_ptr] <= addr_in_tdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            addr_in_tready <= 1'b0;
            mover_dest_address <= 64'd0;
            bcount <= 32'd0;
            timer <= 32'd0;
            worst <= 2'd0;
            timeout <= 1'b0;
            moves_completed <= 32'd0;
            error_count <= 16'd0;
        end else begin
            state <= state_d;
            count <= count_d;
            addr_in_tready <= count_d != (AW+1)'(FIFO_DEPTH);
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                mover_dest_address <= mem[rd_ptr];
            end
            if (state == START) begin
                bcount <= 32'd0;
                timer <= 32'd0;
                worst <= 2'd0;
                timeout <= 1'b0;
            end else if (state == WAIT_B) begin
                if (dst_bvalid) begin
                    bcount <= bcount + 32'd1;
                    worst <= dst_bresp > worst ? dst_bresp : worst;
                    timer <= 32'd0;
                end else begin
                    timer <= timer + 32'd1;
                    if (timer + 32'd1 == TMO) timeout <= 1'b1;
                end
            end
            if (done_hs) moves_completed <= moves_completed + 32'd1;
            error_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed checks of queueing, B tracking, status, timeout, backpressure and reset
module tb_move_scheduler;
    logic clk = 1'b0, reset = 1'b1;
    logic [63:0] addr_in_tdata = 64'd0;
    logic addr_in_tvalid = 1'b0, addr_in_tready, mover_start;
    logic [63:0] mover_dest_address, done_tdata;
    logic dst_bvalid = 1'b0;
    logic [1:0] dst_bresp = 2'd0;
    logic [2:0] done_tuser;
    logic done_tvalid, done_tready = 1'b0, busy;
    logic [31:0] moves_completed;
    logic [15:0] error_count;
    int tests = 0, failed = 0;
    int nstarts = 0, b_seen = 0, overlap = 0;
    logic [63:0] start_log [$];

    move_scheduler #(.BYTE_COUNT(16384), .BURST_SIZE(4096), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset),
        .addr_in_tdata(addr_in_tdata), .addr_in_tvalid(addr_in_tvalid), .addr_in_tready(addr_in_tready),
        .mover_start(mover_start), .mover_dest_address(mover_dest_address),
        .dst_bvalid(dst_bvalid), .dst_bresp(dst_bresp),
        .done_tdata(done_tdata), .done_tuser(done_tuser), .done_tvalid(done_tvalid), .done_tready(done_tready),
        .busy(busy), .moves_completed(moves_completed), .error_count(error_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dst_bvalid) b_seen++;
        if (mover_start) begin
            if (nstarts > 0 && b_seen < 4) overlap++;
            b_seen = 0;
            nstarts++;
            start_log.push_back(mover_dest_address);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] a);
        int k = 0;
        addr_in_tdata = a;
        addr_in_tvalid = 1'b1;
        while (!addr_in_tready && k < 200) begin
            tick(1);
            k++;
        end
        if (k == 200) chk("push_ready_timeout", 64'(addr_in_tready), 64'd1);
        tick(1);
        addr_in_tvalid = 1'b0;
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (nstarts < n && k < 200) begin
            tick(1);
            k++;
        end
        chk("start_seen", 64'(nstarts >= n), 64'd1);
    endtask

    task automatic serve(input int n, input logic [7:0] rs);
        for (int i = 0; i < n; i++) begin
            tick(4);
            dst_bvalid = 1'b1;
            dst_bresp = rs[2*i +: 2];
            tick(1);
            dst_bvalid = 1'b0;
            dst_bresp = 2'd0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, 64'(addr_in_tready), 64'd0);
        chk({tag, "_start"}, 64'(mover_start), 64'd0);
        chk({tag, "_dest"}, mover_dest_address, 64'd0);
        chk({tag, "_dvalid"}, 64'(done_tvalid), 64'd0);
        chk({tag, "_ddata"}, done_tdata, 64'd0);
        chk({tag, "_duser"}, 64'(done_tuser), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_moves"}, 64'(moves_completed), 64'd0);
        chk({tag, "_errs"}, 64'(error_count), 64'd0);
    endtask

    initial begin
        int s;
        tick(3);
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick(1);
        chk("tready_after_rst", 64'(addr_in_tready), 64'd1);

        push(64'h1_0000_0000);
        chk("busy_queued", 64'(busy), 64'd1);
        wait_starts(1);
        chk("m1_dest", mover_dest_address, 64'h1_0000_0000);
        serve(4, 8'h00);
        chk("m1_dvalid", 64'(done_tvalid), 64'd1);
        chk("m1_ddata", done_tdata, 64'h1_0000_0000);
        chk("m1_duser", 64'(done_tuser), 64'd0);
        tick(2);
        chk("m1_hold_valid", 64'(done_tvalid), 64'd1);
        chk("m1_hold_data", done_tdata, 64'h1_0000_0000);
        done_tready = 1'b1;
        tick(1);
        chk("m1_dvalid_off", 64'(done_tvalid), 64'd0);
        chk("m1_moves", 64'(moves_completed), 64'd1);
        chk("m1_starts", 64'(nstarts), 64'd1);

        push(64'h1000);
        push(64'h2000);
        push(64'h3000);
        for (int i = 0; i < 3; i++) begin
            wait_starts(2 + i);
            serve(4, 8'h00);
        end
        tick(3);
        chk("q_starts", 64'(nstarts), 64'd4);
        chk("q_addr0", start_log[1], 64'h1000);
        chk("q_addr1", start_log[2], 64'h2000);
        chk("q_addr2", start_log[3], 64'h3000);
        chk("q_overlap", 64'(overlap), 64'd0);
        chk("q_moves", 64'(moves_completed), 64'd4);
        chk("q_errs", 64'(error_count), 64'd0);

        push(64'd0);
        chk("zero_err", 64'(error_count), 64'd1);
        push(64'h5000);
        wait_starts(5);
        serve(4, 8'h00);
        tick(3);
        chk("zero_starts", 64'(nstarts), 64'd5);
        chk("zero_addr", start_log[4], 64'h5000);
        chk("zero_moves", 64'(moves_completed), 64'd5);
        chk("zero_errs_after", 64'(error_count), 64'd1);

        done_tready = 1'b0;
        push(64'h6000);
        wait_starts(6);
        serve(4, 8'b11_10_00_00);
        chk("st_dvalid", 64'(done_tvalid), 64'd1);
        chk("st_duser", 64'(done_tuser), 64'b011);
        chk("st_ddata", done_tdata, 64'h6000);
        done_tready = 1'b1;
        tick(1);
        chk("st_errs", 64'(error_count), 64'd2);
        chk("st_moves", 64'(moves_completed), 64'd6);
        done_tready = 1'b0;

        push(64'h7000);
        wait_starts(7);
        serve(2, 8'h00);
        tick(49);
        chk("to_not_yet", 64'(done_tvalid), 64'd0);
        tick(1);
        chk("to_dvalid", 64'(done_tvalid), 64'd1);
        chk("to_duser", 64'(done_tuser), 64'b100);
        dst_bvalid = 1'b1;
        tick(1);
        dst_bvalid = 1'b0;
        chk("late_b_err", 64'(error_count), 64'd3);
        chk("to_still_report", 64'(done_tvalid), 64'd1);
        done_tready = 1'b1;
        tick(1);
        chk("to_errs", 64'(error_count), 64'd4);
        chk("to_moves", 64'(moves_completed), 64'd7);
        done_tready = 1'b0;

        for (int i = 0; i < 16; i++) push(64'h10000 + 64'(i) * 64'h1000);
        chk("fill_ready_16", 64'(addr_in_tready), 64'd1);
        push(64'h20000);
        chk("fill_full", 64'(addr_in_tready), 64'd0);
        chk("fill_busy", 64'(busy), 64'd1);
        chk("fill_first_start", start_log[7], 64'h10000);
        addr_in_tdata = 64'h30000;
        addr_in_tvalid = 1'b1;
        tick(3);
        chk("fill_stays_full", 64'(addr_in_tready), 64'd0);
        addr_in_tvalid = 1'b0;
        dst_bvalid = 1'b1;
        tick(1);
        dst_bvalid = 1'b0;
        s = nstarts;
        reset = 1'b1;
        tick(2);
        chk_reset_outputs("mid");
        reset = 1'b0;
        tick(20);
        chk("post_rst_nostart", 64'(nstarts), 64'(s));
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_tready", 64'(addr_in_tready), 64'd1);
        chk("post_rst_errs", 64'(error_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
